// File: rtl/sdram_line_responder_pkg.sv
// Shared types and constants for the SDRAM line responder: response codes,
// line geometry, channel state encodings and the address range helper.
package sdram_line_responder_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int LINE_BITS = 512;
   localparam int STRB_BITS = 64;
   localparam int ADDR_BITS = 31;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

   // Any address bit above the line index makes the request unserviceable.
   function automatic logic addr_out_of_range(input logic [ADDR_BITS-1:0] addr,
                                              input int lines_log2);
      return (addr >> (6 + lines_log2)) != '0;
   endfunction

endpackage

// File: rtl/sdram_line_responder_line_ram.sv
// Line storage: one 512-bit word per line, byte-granular write enables and a
// registered read port; a same-edge read and write to one line returns old data.
module sdram_line_responder_line_ram
   import sdram_line_responder_pkg::*;
#(
   parameter int LINES_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [LINES_LOG2-1:0] rd_idx,
   output logic [LINE_BITS-1:0]  rd_dat,
   input  logic                  wr_en,
   input  logic [LINES_LOG2-1:0] wr_idx,
   input  logic [STRB_BITS-1:0]  wr_strb,
   input  logic [LINE_BITS-1:0]  wr_dat
);

   logic [LINE_BITS-1:0] mem [1 << LINES_LOG2];

   always_ff @(posedge clk) begin
      if (rd_en)
         rd_dat <= mem[rd_idx];
      if (wr_en) begin
         for (int b = 0; b < STRB_BITS; b++) begin
            if (wr_strb[b])
               mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/sdram_line_responder.sv
// AXI4 single-beat 512-bit line slave with fixed read/write response latencies;
// read and write channels are independent, each with one transaction in flight.
module sdram_line_responder
   import sdram_line_responder_pkg::*;
#(
   parameter int LINES_LOG2    = 10,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [30:0]          s_axi_araddr,
   input  logic [7:0]           s_axi_arlen,
   input  logic                 s_axi_arvalid,
   output logic                 s_axi_arready,
   output logic [LINE_BITS-1:0] s_axi_rdata,
   output logic [1:0]           s_axi_rresp,
   output logic [3:0]           s_axi_rid,
   output logic                 s_axi_rlast,
   output logic                 s_axi_rvalid,
   input  logic                 s_axi_rready,
   input  logic [30:0]          s_axi_awaddr,
   input  logic [7:0]           s_axi_awlen,
   input  logic                 s_axi_awvalid,
   output logic                 s_axi_awready,
   input  logic [LINE_BITS-1:0] s_axi_wdata,
   input  logic [STRB_BITS-1:0] s_axi_wstrb,
   input  logic                 s_axi_wlast,
   input  logic                 s_axi_wvalid,
   output logic                 s_axi_wready,
   output logic [1:0]           s_axi_bresp,
   output logic [3:0]           s_axi_bid,
   output logic                 s_axi_bvalid,
   input  logic                 s_axi_bready
);

   localparam int RCW = $clog2(READ_LATENCY + 1);
   localparam int WCW = $clog2(WRITE_LATENCY + 1);

   r_state_t              r_state;
   logic [RCW-1:0]        r_cnt;
   logic [LINES_LOG2-1:0] r_idx;
   logic                  r_err;
   logic                  arready_q;
   logic                  rvalid_q;
   logic [1:0]            rresp_q;

   w_state_t              w_state;
   logic [WCW-1:0]        w_cnt;
   logic [LINES_LOG2-1:0] aw_idx;
   logic                  aw_err;
   logic                  aw_held;
   logic                  w_held;
   logic [LINE_BITS-1:0]  w_dat;
   logic [STRB_BITS-1:0]  w_strb;
   logic                  awready_q;
   logic                  wready_q;
   logic                  bvalid_q;
   logic [1:0]            bresp_q;

   logic                  ram_rd_en;
   logic                  ram_wr_en;
   logic [LINE_BITS-1:0]  ram_rd_dat;
   logic                  w_last_fire;

   assign w_last_fire = s_axi_wvalid && wready_q && s_axi_wlast;
   assign ram_rd_en   = (r_state == R_WAIT) && (r_cnt == '0) && !r_err;
   // Gated by rst so a commit pending at the reset edge is dropped.
   assign ram_wr_en   = !rst && (w_state == W_IDLE) && aw_held && w_held && !aw_err;

   sdram_line_responder_line_ram #(
      .LINES_LOG2(LINES_LOG2)
   ) u_line_ram (
      .clk    (clk),
      .rd_en  (ram_rd_en),
      .rd_idx (r_idx),
      .rd_dat (ram_rd_dat),
      .wr_en  (ram_wr_en),
      .wr_idx (aw_idx),
      .wr_strb(w_strb),
      .wr_dat (w_dat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= R_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_err     <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (s_axi_arvalid && arready_q) begin
                  r_idx     <= s_axi_araddr[6 +: LINES_LOG2];
                  r_err     <= addr_out_of_range(s_axi_araddr, LINES_LOG2) ||
                               (s_axi_arlen != 8'd0);
                  r_cnt     <= RCW'(READ_LATENCY - 1);
                  arready_q <= 1'b0;
                  r_state   <= R_WAIT;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_WAIT: begin
               if (r_cnt == '0) begin
                  rvalid_q <= 1'b1;
                  rresp_q  <= r_err ? RESP_SLVERR : RESP_OKAY;
                  r_state  <= R_RESP;
               end else begin
                  r_cnt <= r_cnt - RCW'(1);
               end
            end
            R_RESP: begin
               if (s_axi_rready) begin
                  rvalid_q  <= 1'b0;
                  rresp_q   <= RESP_OKAY;
                  arready_q <= 1'b1;
                  r_state   <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   // Write payload is only ever consumed at commit, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_state == W_IDLE && !w_held && w_last_fire) begin
         w_dat  <= s_axi_wdata;
         w_strb <= s_axi_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         w_cnt     <= '0;
         aw_idx    <= '0;
         aw_err    <= 1'b0;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_held && w_held) begin
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
                  w_cnt   <= WCW'(WRITE_LATENCY - 1);
                  w_state <= W_WAIT;
               end else begin
                  if (s_axi_awvalid && awready_q) begin
                     aw_idx    <= s_axi_awaddr[6 +: LINES_LOG2];
                     aw_err    <= addr_out_of_range(s_axi_awaddr, LINES_LOG2) ||
                                  (s_axi_awlen != 8'd0);
                     aw_held   <= 1'b1;
                     awready_q <= 1'b0;
                  end else if (!aw_held) begin
                     awready_q <= 1'b1;
                  end
                  // Non-last beats are accepted and dropped.
                  if (w_last_fire) begin
                     w_held   <= 1'b1;
                     wready_q <= 1'b0;
                  end else if (!w_held) begin
                     wready_q <= 1'b1;
                  end
               end
            end
            W_WAIT: begin
               if (w_cnt == '0) begin
                  bvalid_q <= 1'b1;
                  bresp_q  <= aw_err ? RESP_SLVERR : RESP_OKAY;
                  w_state  <= W_RESP;
               end else begin
                  w_cnt <= w_cnt - WCW'(1);
               end
            end
            W_RESP: begin
               if (s_axi_bready) begin
                  bvalid_q  <= 1'b0;
                  bresp_q   <= RESP_OKAY;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  w_state   <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = (rvalid_q && !r_err) ? ram_rd_dat : '0;
   assign s_axi_rid     = 4'd0;
   assign s_axi_rlast   = rvalid_q;
   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_bid     = 4'd0;

endmodule

// File: tb/tb_sdram_line_responder.sv
// Directed and randomized bench for sdram_line_responder against a line-array model.
module tb_sdram_line_responder;

   localparam int LL = 10;
   localparam int RL = 4;
   localparam int WL = 2;
   localparam int NLINES = 1 << LL;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [30:0]  s_axi_araddr = '0;
   logic [7:0]   s_axi_arlen = '0;
   logic         s_axi_arvalid = 1'b0;
   logic         s_axi_arready;
   logic [511:0] s_axi_rdata;
   logic [1:0]   s_axi_rresp;
   logic [3:0]   s_axi_rid;
   logic         s_axi_rlast;
   logic         s_axi_rvalid;
   logic         s_axi_rready = 1'b0;
   logic [30:0]  s_axi_awaddr = '0;
   logic [7:0]   s_axi_awlen = '0;
   logic         s_axi_awvalid = 1'b0;
   logic         s_axi_awready;
   logic [511:0] s_axi_wdata = '0;
   logic [63:0]  s_axi_wstrb = '0;
   logic         s_axi_wlast = 1'b0;
   logic         s_axi_wvalid = 1'b0;
   logic         s_axi_wready;
   logic [1:0]   s_axi_bresp;
   logic [3:0]   s_axi_bid;
   logic         s_axi_bvalid;
   logic         s_axi_bready = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [511:0] model [NLINES];

   always #5 clk = ~clk;

   sdram_line_responder #(
      .LINES_LOG2(LL), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rid(s_axi_rid),
      .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [511:0] rnd_line();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic is_err(input logic [30:0] addr, input logic [7:0] len);
      return (int'(addr) >= (1 << (6 + LL))) || (len != 8'd0);
   endfunction

   function automatic int line_of(input logic [30:0] addr);
      return (int'(addr) / 64) % NLINES;
   endfunction

   task automatic rd(input logic [30:0] addr, input logic [7:0] len, input int hold,
                     input string tag);
      logic         err;
      logic [511:0] exp;
      logic         ar_seen;
      int           n;
      err = is_err(addr, len);
      exp = err ? 512'd0 : model[line_of(addr)];
      chk({tag, " ar_rdy"}, 512'(s_axi_arready), 512'(1));
      s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
      n = 0;
      while (!s_axi_arready && n < 20) begin tick(); n++; end
      tick();
      s_axi_arvalid = 1'b0;
      n = 0; ar_seen = 1'b0;
      while (!s_axi_rvalid && n < 50) begin
         if (s_axi_arready) ar_seen = 1'b1;
         tick(); n++;
      end
      chk({tag, " r_lat"}, 512'(n), 512'(RL));
      chk({tag, " rvalid"}, 512'(s_axi_rvalid), 512'(1));
      chk({tag, " ar_busy"}, 512'(ar_seen | s_axi_arready), 512'(0));
      chk({tag, " rresp"}, 512'(s_axi_rresp), err ? 512'(2) : 512'(0));
      chk({tag, " rdata"}, s_axi_rdata, exp);
      chk({tag, " rlast_rid"}, 512'({s_axi_rlast, s_axi_rid}), 512'(5'b10000));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, " hold_rdata"}, s_axi_rdata, exp);
         chk({tag, " hold_ar"}, 512'({s_axi_rvalid, s_axi_arready}), 512'(2'b10));
      end
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      chk({tag, " r_done"}, 512'({s_axi_rvalid, s_axi_arready}), 512'(2'b01));
   endtask

   task automatic wr(input logic [30:0] addr, input logic [7:0] len, input logic [511:0] data,
                     input logic [63:0] strb, input int w_lead, input int nbeats,
                     input string tag);
      logic err;
      int   n;
      int   idx;
      err = is_err(addr, len);
      idx = line_of(addr);
      chk({tag, " aw_w_rdy"}, 512'({s_axi_awready, s_axi_wready}), 512'(2'b11));
      for (int i = 0; i < nbeats; i++) begin
         s_axi_wvalid = 1'b1;
         s_axi_wlast  = (i == nbeats - 1);
         s_axi_wdata  = s_axi_wlast ? data : rnd_line();
         s_axi_wstrb  = s_axi_wlast ? strb : '1;
         if (s_axi_wlast && w_lead == 0) begin
            s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
         end
         tick();
      end
      s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      if (w_lead == 0) begin
         s_axi_awvalid = 1'b0;
      end else begin
         repeat (w_lead - 1) tick();
         chk({tag, " w_held"}, 512'({s_axi_awready, s_axi_wready}), 512'(2'b10));
         s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
         tick();
         s_axi_awvalid = 1'b0;
      end
      n = 0;
      while (!s_axi_bvalid && n < 50) begin tick(); n++; end
      if (!err) begin
         for (int b = 0; b < 64; b++)
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
      end
      chk({tag, " b_lat"}, 512'(n), 512'(WL + 1));
      chk({tag, " bvalid"}, 512'(s_axi_bvalid), 512'(1));
      chk({tag, " bresp"}, 512'(s_axi_bresp), err ? 512'(2) : 512'(0));
      chk({tag, " bid_rdy"}, 512'({s_axi_bid, s_axi_awready, s_axi_wready}), 512'(0));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      chk({tag, " b_done"}, 512'({s_axi_bvalid, s_axi_awready, s_axi_wready}), 512'(3'b011));
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] old5, new5, data9;
      logic         seen_valid;
      for (int i = 0; i < NLINES; i++) model[i] = '0;

      // Reset values
      repeat (3) tick();
      chk("rst_readys", 512'({s_axi_arready, s_axi_awready, s_axi_wready}), 512'(0));
      chk("rst_valids", 512'({s_axi_rvalid, s_axi_bvalid}), 512'(0));
      chk("rst_resps", 512'({s_axi_rresp, s_axi_bresp}), 512'(0));
      chk("rst_rdata", s_axi_rdata, 512'(0));
      chk("rst_ids_last", 512'({s_axi_rid, s_axi_bid, s_axi_rlast}), 512'(0));
      rst = 1'b0;
      tick();
      chk("rst_exit_readys", 512'({s_axi_arready, s_axi_awready, s_axi_wready}), 512'(3'b111));

      // A5 line, AW and W together, then read back
      wr(31'h40, 8'd0, {64{8'hA5}}, '1, 0, 1, "a5_wr");
      rd(31'h40, 8'd0, 0, "a5_rd");

      // Partial strobe with W leading AW by 3 cycles
      wr(31'h80, 8'd0, 512'd0, '1, 0, 1, "l2_zero");
      wr(31'h80, 8'd0, rnd_line(), 64'h0000_0000_0000_000F, 3, 1, "l2_partial");
      rd(31'h80, 8'd0, 0, "l2_rd");

      // Error responses: out of range and nonzero burst lengths
      wr(31'h0, 8'd0, {64{8'h3C}}, '1, 0, 1, "l0_init");
      rd(31'h0010_0000, 8'd0, 0, "oob_rd");
      wr(31'h0010_0000, 8'd0, rnd_line(), '1, 0, 1, "oob_wr");
      rd(31'h0, 8'd0, 0, "l0_after_oob");
      rd(31'h40, 8'd1, 0, "arlen_err");
      wr(31'hC0, 8'd1, rnd_line(), '1, 0, 2, "awlen_err");
      rd(31'hC0, 8'd0, 0, "l3_after_err");

      // rready held low, then an immediate back-to-back read
      rd(31'h40, 8'd0, 5, "hold_rd");
      rd(31'h80, 8'd0, 0, "b2b_rd");

      // Read sample and write commit to line 5 on the same edge
      wr(31'h140, 8'd0, {64{8'h11}}, '1, 0, 1, "l5_init");
      old5 = model[5];
      new5 = rnd_line();
      chk("same_ar_rdy", 512'(s_axi_arready), 512'(1));
      s_axi_araddr = 31'h140; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0;
      tick(); tick();
      s_axi_awaddr = 31'h140; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
      s_axi_wdata = new5; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      tick();
      chk("same_rvalid", 512'(s_axi_rvalid), 512'(1));
      chk("same_rdata_old", s_axi_rdata, old5);
      s_axi_rready = 1'b1;
      tick();
      s_axi_rready = 1'b0;
      tick();
      chk("same_bvalid", 512'({s_axi_bvalid, s_axi_bresp}), 512'(3'b100));
      s_axi_bready = 1'b1;
      tick();
      s_axi_bready = 1'b0;
      model[5] = new5;
      rd(31'h140, 8'd0, 0, "same_rd_new");

      // Reset while read waits and write has committed
      data9 = rnd_line();
      s_axi_araddr = 31'h1C0; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
      s_axi_awaddr = 31'h240; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
      s_axi_wdata = data9; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
      tick();
      s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      tick();
      model[9] = data9;
      rst = 1'b1;
      tick();
      chk("midrst_all_low", 512'({s_axi_rvalid, s_axi_bvalid, s_axi_arready,
                                  s_axi_awready, s_axi_wready}), 512'(0));
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_readys", 512'({s_axi_arready, s_axi_awready, s_axi_wready}), 512'(3'b111));
      seen_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (s_axi_rvalid || s_axi_bvalid) seen_valid = 1'b1;
         tick();
      end
      chk("midrst_no_valid", 512'(seen_valid | s_axi_rvalid | s_axi_bvalid), 512'(0));
      rd(31'h240, 8'd0, 0, "midrst_persist");

      // Randomized traffic over a handful of lines
      for (int it = 0; it < 30; it++) begin
         logic [30:0] addr;
         addr = 31'($urandom_range(0, 15) * 64 + $urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) addr = addr | 31'h0100_0000;
         if ($urandom_range(0, 1) == 1)
            wr(addr, 8'd0, rnd_line(), {$urandom, $urandom}, $urandom_range(0, 2), 1, "rnd_wr");
         else
            rd(addr, 8'd0, $urandom_range(0, 3), "rnd_rd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
